// File: rtl/sdf_bf_stage_64_if.sv
// +----------------------------------------------------------------------+
// | sdf_bf_stage_64_if: streaming sample/twiddle bus for the SDF stage     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface sdf_bf_stage_64_if #(
  parameter int WIDTH = 24
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] din_r;
  logic signed [WIDTH-1:0] din_i;
  logic [1:0]              state;
  logic signed [WIDTH-1:0] w_r;
  logic signed [WIDTH-1:0] w_i;
  logic                    out_valid;
  logic signed [WIDTH-1:0] dout_r;
  logic signed [WIDTH-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

`default_nettype wire

// File: rtl/sdf_bf_stage_64.sv
// +----------------------------------------------------------------------+
// | sdf_bf_stage_64: radix-2 delay-feedback butterfly stage, 128-pt span   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module sdf_bf_stage_64 #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdf_bf_stage_64_if.slave     bus
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;

  logic signed [WIDTH-1:0] mem_r_q [DEPTH];
  logic signed [WIDTH-1:0] mem_i_q [DEPTH];
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] dout_r_q, dout_r_d;
  logic signed [WIDTH-1:0] dout_i_q, dout_i_d;

  logic                      adv;
  logic signed [WIDTH-1:0]   x_r, x_i, h_r, h_i;
  logic signed [WIDTH-1:0]   push_r_d, push_i_d;
  logic [WIDTH:0]            sum_r, sum_i, dif_r, dif_i;
  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   tw_r, tw_i;

  // Line is always full, so the head slot is also where the new tail lands.
  always_comb begin
    adv = bus.in_valid | (bus.state != 2'd0);
    x_r = bus.in_valid ? bus.din_r : '0;
    x_i = bus.in_valid ? bus.din_i : '0;
    h_r = mem_r_q[ptr_q];
    h_i = mem_i_q[ptr_q];

    sum_r = {h_r[WIDTH-1], h_r} + {x_r[WIDTH-1], x_r};
    sum_i = {h_i[WIDTH-1], h_i} + {x_i[WIDTH-1], x_i};
    dif_r = {h_r[WIDTH-1], h_r} - {x_r[WIDTH-1], x_r};
    dif_i = {h_i[WIDTH-1], h_i} - {x_i[WIDTH-1], x_i};

    p_rr = $signed({{WIDTH{h_r[WIDTH-1]}}, h_r}) * $signed({{WIDTH{bus.w_r[WIDTH-1]}}, bus.w_r});
    p_ii = $signed({{WIDTH{h_i[WIDTH-1]}}, h_i}) * $signed({{WIDTH{bus.w_i[WIDTH-1]}}, bus.w_i});
    p_ri = $signed({{WIDTH{h_r[WIDTH-1]}}, h_r}) * $signed({{WIDTH{bus.w_i[WIDTH-1]}}, bus.w_i});
    p_ir = $signed({{WIDTH{h_i[WIDTH-1]}}, h_i}) * $signed({{WIDTH{bus.w_r[WIDTH-1]}}, bus.w_r});
    tw_r = $signed({p_rr[2*WIDTH-1], p_rr}) - $signed({p_ii[2*WIDTH-1], p_ii});
    tw_i = $signed({p_ri[2*WIDTH-1], p_ri}) + $signed({p_ir[2*WIDTH-1], p_ir});

    push_r_d    = x_r;
    push_i_d    = x_i;
    out_valid_d = 1'b0;
    dout_r_d    = '0;
    dout_i_d    = '0;

    // State 3 falls into the default: same as fill.
    case (bus.state)
      ST_BFLY: begin
        push_r_d    = WIDTH'(dif_r);
        push_i_d    = WIDTH'(dif_i);
        out_valid_d = 1'b1;
        dout_r_d    = WIDTH'(sum_r);
        dout_i_d    = WIDTH'(sum_i);
      end
      ST_TWID: begin
        out_valid_d = 1'b1;
        dout_r_d    = WIDTH'(tw_r >>> FRAC);
        dout_i_d    = WIDTH'(tw_i >>> FRAC);
      end
      default: ;
    endcase

    if (!adv)
      ptr_d = ptr_q;
    else if (ptr_q == PTR_W'(DEPTH - 1))
      ptr_d = '0;
    else
      ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r_q[i] <= '0;
        mem_i_q[i] <= '0;
      end
    end else if (adv) begin
      mem_r_q[ptr_q] <= push_r_d;
      mem_i_q[ptr_q] <= push_i_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;

endmodule

`default_nettype wire

// File: tb/tb_sdf_bf_stage_64.sv
// Directed bench for sdf_bf_stage_64: drives the ROM phase sequence and checks
// butterfly and twiddle outputs against hand values and an algorithmic model.
`timescale 1ns/1ps
`default_nettype none

module tb_sdf_bf_stage_64;

  localparam int W = 24;
  localparam int D = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdf_bf_stage_64_if #(.WIDTH(W)) bus ();

  sdf_bf_stage_64 #(.DEPTH(D), .WIDTH(W), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int w_re [D];
  int w_im [D];
  int fr_r [256];
  int fr_i [256];
  int s1_r [128];
  int s1_i [128];
  int s2_r [128];
  int s2_i [128];
  int fill_v, v_cnt;
  logic last_v;

  function automatic int wrap(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic drive(input logic v, input int dr, input int di,
                       input logic [1:0] st, input int k);
    bus.in_valid = v;
    bus.din_r    = v ? W'(dr) : W'($urandom);
    bus.din_i    = v ? W'(di) : W'($urandom);
    bus.state    = st;
    bus.w_r      = W'(w_re[k]);
    bus.w_i      = W'(w_im[k]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.state    = 2'd0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    bus.w_r      = '0;
    bus.w_i      = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frames();
    for (int n = 0; n < 256; n++) begin
      fr_r[n] = 0;
      fr_i[n] = 0;
    end
  endtask

  // Fill, then per frame 64 butterfly + 64 twiddle cycles; next frame's first
  // half streams in during twiddle, the last frame flushes with in_valid=0.
  task automatic run_frames(input int nf);
    fill_v = 0;
    v_cnt  = 0;
    for (int k = 0; k < D; k++) begin
      drive(1'b1, fr_r[k], fr_i[k], 2'd0, k);
      if (bus.out_valid !== 1'b0) fill_v++;
    end
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < D; k++) begin
        drive(1'b1, fr_r[f*128+64+k], fr_i[f*128+64+k], 2'd1, k);
        s1_r[f*64+k] = int'(bus.dout_r);
        s1_i[f*64+k] = int'(bus.dout_i);
        if (bus.out_valid === 1'b1) v_cnt++;
      end
      for (int k = 0; k < D; k++) begin
        if (f + 1 < nf) drive(1'b1, fr_r[(f+1)*128+k], fr_i[(f+1)*128+k], 2'd2, k);
        else            drive(1'b0, 0, 0, 2'd2, k);
        s2_r[f*64+k] = int'(bus.dout_r);
        s2_i[f*64+k] = int'(bus.dout_i);
        if (bus.out_valid === 1'b1) v_cnt++;
      end
    end
    drive(1'b0, 0, 0, 2'd0, 0);
    last_v = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.dout_r !== '0 || bus.dout_i !== '0) begin
      n_fail++; $display("FAIL reset_dout: got %0d/%0d want 0/0", bus.dout_r, bus.dout_i);
    end
    do_reset();
  endtask

  task automatic test_impulse();
    do_reset();
    clear_frames();
    fr_r[0] = 256;
    run_frames(1);
    for (int k = 0; k < D; k++) begin
      n_tests++;
      if (s1_r[k] !== ((k == 0) ? 256 : 0) || s1_i[k] !== 0 ||
          s2_r[k] !== ((k == 0) ? 256 : 0) || s2_i[k] !== 0) begin
        n_fail++;
        $display("FAIL impulse k=%0d: bf %0d/%0d tw %0d/%0d want bf %0d/0 tw %0d/0",
                 k, s1_r[k], s1_i[k], s2_r[k], s2_i[k], (k == 0) ? 256 : 0, (k == 0) ? 256 : 0);
      end
    end
    n_tests++;
    if (fill_v !== 0 || v_cnt !== 128 || last_v !== 1'b0) begin
      n_fail++;
      $display("FAIL impulse_valid: fill=%0d active=%0d last=%b want 0/128/0", fill_v, v_cnt, last_v);
    end
  endtask

  task automatic test_dc();
    do_reset();
    clear_frames();
    for (int n = 0; n < 128; n++) fr_r[n] = 100;
    run_frames(1);
    for (int k = 0; k < D; k++) begin
      n_tests++;
      if (s1_r[k] !== 200 || s1_i[k] !== 0 || s2_r[k] !== 0 || s2_i[k] !== 0) begin
        n_fail++;
        $display("FAIL dc k=%0d: bf %0d/%0d tw %0d/%0d want bf 200/0 tw 0/0",
                 k, s1_r[k], s1_i[k], s2_r[k], s2_i[k]);
      end
    end
  endtask

  // Period-2 input: samples k and k+64 share sign, so they add and cancel.
  task automatic test_alternating();
    do_reset();
    clear_frames();
    for (int n = 0; n < 128; n++) fr_r[n] = (n % 2 == 0) ? 100 : -100;
    run_frames(1);
    for (int k = 0; k < D; k++) begin
      n_tests++;
      if (s1_r[k] !== ((k % 2 == 0) ? 200 : -200) || s1_i[k] !== 0 ||
          s2_r[k] !== 0 || s2_i[k] !== 0) begin
        n_fail++;
        $display("FAIL alternating k=%0d: bf %0d/%0d tw %0d/%0d want bf %0d/0 tw 0/0",
                 k, s1_r[k], s1_i[k], s2_r[k], s2_i[k], (k % 2 == 0) ? 200 : -200);
      end
    end
  endtask

  // w[1] = 256-13j, w[2] = 255-25j.
  task automatic test_twiddle();
    do_reset();
    clear_frames();
    fr_r[1] = 200;
    fr_i[2] = 256;
    run_frames(1);
    n_tests++;
    if (s1_r[1] !== 200 || s1_i[1] !== 0 || s1_r[2] !== 0 || s1_i[2] !== 256) begin
      n_fail++;
      $display("FAIL twiddle_bf: k1 %0d/%0d k2 %0d/%0d want 200/0 0/256", s1_r[1], s1_i[1], s1_r[2], s1_i[2]);
    end
    n_tests++;
    if (s2_r[1] !== 200 || s2_i[1] !== -11) begin
      n_fail++; $display("FAIL twiddle_k1: got %0d/%0d want 200/-11", s2_r[1], s2_i[1]);
    end
    n_tests++;
    if (s2_r[2] !== 25 || s2_i[2] !== 255) begin
      n_fail++; $display("FAIL twiddle_k2: got %0d/%0d want 25/255", s2_r[2], s2_i[2]);
    end
    n_tests++;
    if (s2_r[0] !== 0 || s2_i[0] !== 0 || s2_r[3] !== 0 || s2_i[3] !== 0) begin
      n_fail++; $display("FAIL twiddle_zero: k0 %0d/%0d k3 %0d/%0d want 0", s2_r[0], s2_i[0], s2_r[3], s2_i[3]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_frames();
    for (int n = 0; n < 128; n++) fr_r[n] = 8388607;
    run_frames(1);
    n_tests++;
    if (s1_r[0] !== -2 || s1_r[63] !== -2 || s1_i[0] !== 0) begin
      n_fail++; $display("FAIL wrap_sum: got %0d/%0d want -2 (0xFFFFFE)", s1_r[0], s1_r[63]);
    end
    n_tests++;
    if (s2_r[0] !== 0 || s2_i[0] !== 0) begin
      n_fail++; $display("FAIL wrap_tw: got %0d/%0d want 0/0", s2_r[0], s2_i[0]);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < D; k++) drive(1'b1, 100, 50, 2'd0, k);
    for (int k = 0; k < 10; k++) drive(1'b1, 7, 3, 2'd1, k);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.dout_r !== 24'sd107) begin
      n_fail++; $display("FAIL midreset_pre: valid %b dout %0d want 1/107", bus.out_valid, bus.dout_r);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: valid %b dout %0d/%0d want 0/0/0", bus.out_valid, bus.dout_r, bus.dout_i);
    end
    #1 rst_n = 1'b1;
    // Peek one butterfly cycle with zero input: head must have been cleared.
    drive(1'b0, 0, 0, 2'd1, 0);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
      n_fail++;
      $display("FAIL midreset_cleared: valid %b dout %0d/%0d want 1/0/0", bus.out_valid, bus.dout_r, bus.dout_i);
    end
    do_reset();
    clear_frames();
    for (int n = 0; n < 128; n++) fr_r[n] = 100;
    run_frames(1);
    n_tests++;
    if (fill_v !== 0 || v_cnt !== 128 || s1_r[0] !== 200 || s2_r[0] !== 0) begin
      n_fail++;
      $display("FAIL midreset_refill: fill=%0d active=%0d bf0=%0d tw0=%0d want 0/128/200/0",
               fill_v, v_cnt, s1_r[0], s2_r[0]);
    end
  endtask

  task automatic test_back_to_back();
    int ar, ai, br, bi, er, ei, dr, di, tr, ti;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      fr_r[n] = int'($urandom_range(0, 2097151)) - 1048576;
      fr_i[n] = int'($urandom_range(0, 2097151)) - 1048576;
    end
    fr_r[5] = 8388607;  fr_r[69] = -8388608;
    fr_i[140] = -8388608; fr_i[204] = 8388607;
    run_frames(2);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < D; k++) begin
        ar = fr_r[f*128+k];    ai = fr_i[f*128+k];
        br = fr_r[f*128+64+k]; bi = fr_i[f*128+64+k];
        er = wrap(longint'(ar) + br);
        ei = wrap(longint'(ai) + bi);
        dr = wrap(longint'(ar) - br);
        di = wrap(longint'(ai) - bi);
        tr = wrap((longint'(dr) * w_re[k] - longint'(di) * w_im[k]) >>> 8);
        ti = wrap((longint'(dr) * w_im[k] + longint'(di) * w_re[k]) >>> 8);
        n_tests++;
        if (s1_r[f*64+k] !== er || s1_i[f*64+k] !== ei) begin
          n_fail++;
          $display("FAIL b2b_bf f=%0d k=%0d: got %0d/%0d want %0d/%0d",
                   f, k, s1_r[f*64+k], s1_i[f*64+k], er, ei);
        end
        n_tests++;
        if (s2_r[f*64+k] !== tr || s2_i[f*64+k] !== ti) begin
          n_fail++;
          $display("FAIL b2b_tw f=%0d k=%0d: got %0d/%0d want %0d/%0d",
                   f, k, s2_r[f*64+k], s2_i[f*64+k], tr, ti);
        end
      end
    end
    n_tests++;
    if (fill_v !== 0 || v_cnt !== 256 || last_v !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid: fill=%0d active=%0d last=%b want 0/256/0", fill_v, v_cnt, last_v);
    end
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin
      w_re[k] =  rnd(256.0 * $cos(2.0 * 3.14159265358979 * k / 128.0));
      w_im[k] = -rnd(256.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
    end
    bus.in_valid = 1'b0;
    bus.state    = 2'd0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    bus.w_r      = '0;
    bus.w_i      = '0;
    test_reset();
    test_impulse();
    test_dc();
    test_alternating();
    test_twiddle();
    test_wrap();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
